// File: rtl/ring_pkg.sv
// rtl/ring_pkg.sv - shared FSM state and fault-code definitions for the ring phase monitor
package ring_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } ring_state_e;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_ONEHOT = 2'b01;
    localparam logic [1:0] ERR_SEQ    = 2'b10;

endpackage

// File: rtl/onehot_encoder.sv
// rtl/onehot_encoder.sv - combinational one-hot to binary encoder with one-hot validity flag
module onehot_encoder #(
    parameter int N = 8
) (
    input  logic [N-1:0]         vec,
    output logic [$clog2(N)-1:0] idx,
    output logic                 is_onehot
);

    localparam int IDX_W = $clog2(N);

    // OR-ing the indices of all set bits is exact for one-hot input; other inputs are flagged invalid anyway.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
    end

    assign is_onehot = (vec != '0) && ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/ring_phase_monitor.sv
// rtl/ring_phase_monitor.sv - tracks a rotating one-hot ring, counts rotations and latches sequence faults
module ring_phase_monitor
    import ring_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         ring_q,
    input  logic                 en,
    input  logic                 clr,
    output logic [$clog2(N)-1:0] phase_idx,
    output logic                 phase_vld,
    output logic                 wrap,
    output logic [CNT_W-1:0]     rot_cnt,
    output logic                 err,
    output logic [1:0]           err_code
);

    localparam int                IDX_W    = $clog2(N);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);

    ring_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             vld_q, vld_d;
    logic             wrap_q, wrap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;

    logic [IDX_W-1:0] enc_idx;
    logic             enc_onehot;
    logic [IDX_W-1:0] expect_idx;

    onehot_encoder #(
        .N(N)
    ) u_enc (
        .vec       (ring_q),
        .idx       (enc_idx),
        .is_onehot (enc_onehot)
    );

    // idx_q doubles as the previous index, so the expected successor is derived from it.
    assign expect_idx = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wrap_d  = 1'b0;
        cnt_d   = cnt_q;
        err_d   = err_q;
        code_d  = code_q;

        if (clr) begin
            state_d = IDLE;
            err_d   = 1'b0;
            code_d  = ERR_NONE;
            cnt_d   = '0;
        end else if (en) begin
            case (state_q)
                IDLE: begin
                    if (enc_onehot) begin
                        idx_d   = enc_idx;
                        state_d = TRACK;
                    end
                end
                TRACK: begin
                    if (!enc_onehot) begin
                        state_d = FAULT;
                        err_d   = 1'b1;
                        code_d  = ERR_ONEHOT;
                    end else if (enc_idx == expect_idx) begin
                        idx_d = enc_idx;
                        if (idx_q == LAST_IDX) begin
                            wrap_d = 1'b1;
                            if (cnt_q != '1) begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                    end else begin
                        state_d = FAULT;
                        err_d   = 1'b1;
                        code_d  = ERR_SEQ;
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        vld_d = (state_d == TRACK);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign phase_idx = idx_q;
    assign phase_vld = vld_q;
    assign wrap      = wrap_q;
    assign rot_cnt   = cnt_q;
    assign err       = err_q;
    assign err_code  = code_q;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// tb/tb_ring_phase_monitor.sv - scoreboard bench for ring_phase_monitor (N=8, counters 16 and 2 bits wide)
module tb_ring_phase_monitor;

    localparam int N = 8;
    localparam int M_IDLE  = 0;
    localparam int M_TRACK = 1;
    localparam int M_FAULT = 2;

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic [7:0] ring_q = 8'h00;
    logic       en     = 1'b0;
    logic       clr    = 1'b0;

    logic [2:0]  a_idx, b_idx;
    logic        a_vld, b_vld, a_wrap, b_wrap, a_err, b_err;
    logic [1:0]  a_code, b_code;
    logic [15:0] a_cnt;
    logic [1:0]  b_cnt;

    always #5 clk = ~clk;

    ring_phase_monitor #(.N(N), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .ring_q(ring_q), .en(en), .clr(clr),
        .phase_idx(a_idx), .phase_vld(a_vld), .wrap(a_wrap),
        .rot_cnt(a_cnt), .err(a_err), .err_code(a_code)
    );

    ring_phase_monitor #(.N(N), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .ring_q(ring_q), .en(en), .clr(clr),
        .phase_idx(b_idx), .phase_vld(b_vld), .wrap(b_wrap),
        .rot_cnt(b_cnt), .err(b_err), .err_code(b_code)
    );

    typedef struct {
        logic [2:0]  idx;
        logic        vld;
        logic        wrap;
        logic [15:0] cnt;
        logic [1:0]  cnt_s;
        logic        err;
        logic [1:0]  code;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    int         m_mode, m_idx, m_cnt, m_cnt_s;
    logic       m_vld, m_wrap, m_err;
    logic [1:0] m_code;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endfunction

    function automatic void model_reset();
        m_mode = M_IDLE; m_idx = 0; m_cnt = 0; m_cnt_s = 0;
        m_vld = 1'b0; m_wrap = 1'b0; m_err = 1'b0; m_code = 2'b00;
    endfunction

    function automatic void model_fault(logic [1:0] code);
        m_mode = M_FAULT; m_err = 1'b1; m_code = code;
    endfunction

    // Rule-level reference: clear beats everything, disable freezes, then IDLE/TRACK/FAULT behaviour.
    function automatic void model_step(logic [7:0] r, logic e_in, logic c_in);
        bit oh;
        int ix;
        oh = ($countones(r) == 1);
        ix = oh ? $clog2(r) : 0;
        m_wrap = 1'b0;
        if (c_in) begin
            m_mode = M_IDLE; m_err = 1'b0; m_code = 2'b00; m_cnt = 0; m_cnt_s = 0;
        end else if (e_in) begin
            if (m_mode == M_IDLE) begin
                if (oh) begin
                    m_idx  = ix;
                    m_mode = M_TRACK;
                end
            end else if (m_mode == M_TRACK) begin
                if (!oh) model_fault(2'b01);
                else if (ix == (m_idx + 1) % N) begin
                    if (ix == 0) begin
                        m_wrap  = 1'b1;
                        m_cnt   = (m_cnt < 65535) ? m_cnt + 1 : 65535;
                        m_cnt_s = (m_cnt_s < 3) ? m_cnt_s + 1 : 3;
                    end
                    m_idx = ix;
                end else model_fault(2'b10);
            end
        end
        m_vld = (m_mode == M_TRACK);
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.idx   = 3'(m_idx);
        e.vld   = m_vld;
        e.wrap  = m_wrap;
        e.cnt   = 16'(m_cnt);
        e.cnt_s = 2'(m_cnt_s);
        e.err   = m_err;
        e.code  = m_code;
        sb_q.push_back(e);
    endfunction

    function automatic logic [7:0] next_ring();
        return 8'(1 << ((m_idx + 1) % N));
    endfunction

    task automatic step(input logic [7:0] r, input logic e_in, input logic c_in);
        ring_q = r;
        en     = e_in;
        clr    = c_in;
        model_step(r, e_in, c_in);
        push_exp();
        @(negedge clk);
    endtask

    task automatic rotate(input int n);
        for (int i = 0; i < n; i++) step(next_ring(), 1'b1, 1'b0);
    endtask

    // Reset lands mid low-phase; the first entry is checked before any clock edge arrives.
    task automatic async_reset();
        #2;
        reset = 1'b1;
        model_reset();
        push_exp();
        push_exp();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk or posedge reset);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("a_phase_idx", 32'(a_idx),  32'(e.idx));
                chk("a_phase_vld", 32'(a_vld),  32'(e.vld));
                chk("a_wrap",      32'(a_wrap), 32'(e.wrap));
                chk("a_rot_cnt",   32'(a_cnt),  32'(e.cnt));
                chk("a_err",       32'(a_err),  32'(e.err));
                chk("a_err_code",  32'(a_code), 32'(e.code));
                chk("b_phase_idx", 32'(b_idx),  32'(e.idx));
                chk("b_phase_vld", 32'(b_vld),  32'(e.vld));
                chk("b_wrap",      32'(b_wrap), 32'(e.wrap));
                chk("b_rot_cnt",   32'(b_cnt),  32'(e.cnt_s));
                chk("b_err",       32'(b_err),  32'(e.err));
                chk("b_err_code",  32'(b_code), 32'(e.code));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, scoreboard depth %0d", sb_q.size());
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int r;
        logic [7:0] v;
        logic e_in, c_in;

        async_reset();

        for (int i = 0; i < 20; i++) step(8'(1 << (i % 8)), 1'b1, 1'b0);
        step(8'h20, 1'b1, 1'b0);
        repeat (3) step(8'($urandom), 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b1);

        repeat (3) step(8'h00, 1'b1, 1'b0);
        step(8'(1 << $urandom_range(0, 7)), 1'b1, 1'b0);
        rotate(5);
        step(8'h00, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b1);
        step(8'(1 << $urandom_range(0, 7)), 1'b1, 1'b0);
        rotate(3);
        step(8'h18, 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b1);

        step(8'(1 << $urandom_range(0, 7)), 1'b1, 1'b0);
        rotate(4);
        repeat (5) step(8'($urandom), 1'b0, 1'b0);
        rotate(3);

        step(8'h40, 1'b1, 1'b1);
        step(8'h01, 1'b1, 1'b0);
        rotate(5 * N);
        rotate(2);
        step(8'h00, 1'b1, 1'b1);
        rotate(2);

        rotate(3);
        async_reset();
        step(8'h00, 1'b1, 1'b0);
        step(8'(1 << $urandom_range(0, 7)), 1'b1, 1'b0);
        rotate(4);

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      v = (m_mode == M_IDLE) ? 8'(1 << $urandom_range(0, 7)) : next_ring();
            else if (r < 75) v = 8'(1 << $urandom_range(0, 7));
            else if (r < 90) v = 8'($urandom);
            else             v = 8'h00;
            e_in = ($urandom_range(0, 9) != 0);
            c_in = (m_mode == M_FAULT) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
            step(v, e_in, c_in);
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ring_phase_monitor.md
RING_PHASE_MONITOR -- requirements
Module: ring_phase_monitor

Interface
REQ-001 Parameter N, default 8: width of the one-hot ring vector under observation; legal range 2..32.
REQ-002 Parameter CNT_W, default 16: width of the rotation counter.
REQ-003 Port clk  input  1: single clock; all state is updated on its rising edge.
REQ-004 Port reset  input  1: reset is asynchronous and active-high.
REQ-005 Port ring_q  input  N: one-hot phase vector from the upstream ring counter; bit i advances to bit i+1 each cycle, and bit N-1 wraps to bit 0.
REQ-006 Port en  input  1: sample enable; when low, all state holds.
REQ-007 Port clr  input  1: synchronous clear of the fault state and the rotation counter.
REQ-008 Port phase_idx  output  $clog2(N): binary index of the last sampled hot bit.
REQ-009 Port phase_vld  output  1: high while the monitor is in TRACK.
REQ-010 Port wrap  output  1: one-cycle pulse on each accepted N-1 -> 0 transition.
REQ-011 Port rot_cnt  output  CNT_W: count of completed rotations, saturating.
REQ-012 Port err  output  1: sticky fault flag.
REQ-013 Port err_code  output  2: 00 none, 01 not-one-hot (zero or multiple bits set), 10 sequence skip or repeat.

Function
REQ-014 The monitor SHALL implement a three-state FSM: IDLE, TRACK, FAULT.
REQ-015 All outputs SHALL be registered; the effect of ring_q sampled at edge k SHALL appear on the outputs after edge k (1-cycle latency).
REQ-016 When en=1, the monitor SHALL encode ring_q every cycle into an index and a one-hot flag (exactly one bit set).
REQ-017 IDLE: a one-hot sample SHALL load phase_idx, store that index as the previous index, and move to TRACK; a non-one-hot sample SHALL remain in IDLE with no error.
REQ-018 TRACK: a one-hot sample whose index equals (previous index + 1) mod N SHALL update phase_idx and stay in TRACK.
REQ-019 TRACK: a non-one-hot sample SHALL move to FAULT with err=1 and err_code=01.
REQ-020 TRACK: a one-hot sample with the wrong index (skip or repeat) SHALL move to FAULT with err=1 and err_code=10.
REQ-021 In FAULT, phase_idx and err_code SHALL hold, phase_vld SHALL be 0, and the FSM SHALL leave FAULT only on clr.
REQ-022 An accepted TRACK transition from index N-1 to index 0 SHALL assert wrap for one cycle and increment rot_cnt.
REQ-023 rot_cnt SHALL saturate at 2^CNT_W-1; wrap SHALL still pulse while rot_cnt is saturated.
REQ-024 clr=1 SHALL force IDLE, err=0, err_code=00 and rot_cnt=0, and SHALL hold phase_idx; this applies regardless of en.
REQ-025 If clr and a fault condition occur in the same cycle, clr SHALL win.
REQ-026 When en=0, the FSM, phase_idx, rot_cnt and err SHALL hold, and wrap SHALL be 0.
REQ-027 The first sample after IDLE SHALL never assert wrap, even if its index is 0.

Reset
REQ-028 Asserting reset SHALL asynchronously force state=IDLE, phase_idx=0, phase_vld=0, wrap=0, rot_cnt=0, err=0 and err_code=00.
REQ-029 Reset asserted mid-rotation SHALL discard the previous index; after release, the monitor SHALL re-acquire from IDLE.

Structure
REQ-030 Shared package ring_pkg SHALL hold the FSM state enumeration (IDLE, TRACK, FAULT) and the err_code constants (ERR_NONE, ERR_ONEHOT, ERR_SEQ).
REQ-031 Sub-module onehot_encoder (purely combinational, parameter N; outputs idx and is_onehot) SHALL perform the encoding; the FSM, counter and flags SHALL reside in ring_phase_monitor.

Verification
REQ-032 N=8, en=1: reset, then drive a legal rotation 01->02->...->80->01 for 20 cycles -> phase_vld=1 from the cycle after the first sample, wrap pulses twice, rot_cnt=2, err=0.
REQ-033 While in TRACK at idx 3, drive 0x20 -> err=1, err_code=10, phase_vld=0, phase_idx holds 3; then assert clr for one cycle -> IDLE, err=0, rot_cnt=0.
REQ-034 While in TRACK, drive 0x00, then separately 0x18 -> err_code=01 in each case; in IDLE, 0x00 raises no error.
REQ-035 Hold en=0 for 5 cycles mid-rotation while ring_q changes randomly -> no state change; resuming with the correct next phase -> no error.
REQ-036 CNT_W=2: run 5 full rotations -> rot_cnt saturates at 3 and wrap pulses 5 times; a fault and clr in the same cycle -> IDLE, err=0.
REQ-037 Assert reset asynchronously between clock edges mid-rotation -> all outputs go to their reset values immediately; after release, re-acquire on the next one-hot sample with no error.
